bus_timer: RTL and testbench



---
 rtl/bus_timer_if.sv | 16 +
 rtl/bus_timer.sv | 124 ++++++++++++
 tb/tb_bus_timer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_if.sv
// Bus interface of the memory-mapped timer: word address, write strobe,
// write data and combinational read data.
//
// Handshake: there is no valid/ready pair. A write happens on every rising
// edge where WE=1, using Addr and Din as they stand at that edge. Reads have
// no strobe: Dout always shows the register selected by Addr[3:2] and
// reading it changes nothing.
interface bus_timer_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/bus_timer.sv
// Countdown timer with CTRL / PRESET / COUNT registers and a level IRQ.
// Supports one-shot (MODE=00, MODE=1x) and auto-reload (MODE=01) operation.
// A write cycle freezes the FSM, COUNT and the irq flag for that edge.
module bus_timer (
  input  logic              clk,
  input  logic              reset,
  bus_timer_if.slave        bus,
  output logic              IRQ,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq;
  logic        r_irq_out;

  logic        w_en;
  logic [1:0]  w_mode;
  logic        w_auto;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_irq_nxt;
  logic        w_im_nxt;
  logic        w_unused_addr;

  assign w_en          = r_ctrl[0];
  assign w_mode        = r_ctrl[2:1];
  assign w_auto        = (w_mode == 2'b01);
  assign w_wr_ctrl     = bus.WE && (bus.Addr[3:2] == 2'd0);
  assign w_wr_preset   = bus.WE && (bus.Addr[3:2] == 2'd1);
  // Only Addr[3:2] is decoded; the bridge has already selected the window.
  assign w_unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};

  // Next value of the irq flag and of IM, so the registered IRQ can follow
  // both in the same edge (masking takes effect right after the write).
  always_comb begin
    w_irq_nxt = r_irq;
    w_im_nxt  = r_ctrl[3];
    if (bus.WE) begin
      if (w_wr_ctrl) w_im_nxt = bus.Din[3];
    end else begin
      case (r_state)
        S_IDLE:  if (w_en) w_irq_nxt = 1'b0;
        S_CNT:   if (w_en && (r_count <= 32'd1)) w_irq_nxt = 1'b1;
        S_INT:   if (w_auto) w_irq_nxt = 1'b0;
        default: w_irq_nxt = r_irq;
      endcase
    end
  end

  // irq flag and the masked, registered interrupt output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq     <= 1'b0;
      r_irq_out <= 1'b0;
    end else begin
      r_irq     <= w_irq_nxt;
      r_irq_out <= w_irq_nxt & w_im_nxt;
    end
  end

  // Register writes (priority) and the timer FSM with COUNT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
    end else if (bus.WE) begin
      if (w_wr_ctrl)   r_ctrl   <= bus.Din[3:0];
      if (w_wr_preset) r_preset <= bus.Din;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_en) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!w_en) begin
            r_state <= S_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            // PRESET of 0 lands here just like 1.
            r_count <= 32'd0;
            r_state <= S_INT;
          end
        end
        S_INT: begin
          // One-shot stops itself; auto-reload just drops irq and restarts.
          if (!w_auto) r_ctrl[0] <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Combinational read mux, no side effects.
  always_comb begin
    case (bus.Addr[3:2])
      2'd0:    bus.Dout = {28'd0, r_ctrl};
      2'd1:    bus.Dout = r_preset;
      2'd2:    bus.Dout = r_count;
      default: bus.Dout = 32'd0;
    endcase
  end

  assign IRQ         = r_irq_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: per-scenario tasks push expected
// {IRQ, COUNT} traces into a queue and pop them edge by edge.
module tb_bus_timer;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INT  = 2'd3;

  logic        clk;
  logic        reset;
  logic        irq;
  logic [1:0]  dbg_state;
  int          n_tests;
  int          n_fail;
  logic [32:0] exp_q[$];

  bus_timer_if bus ();

  bus_timer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .IRQ         (irq),
    .o_dbg_state (dbg_state)
  );

  // clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.Din  = d;
    bus.WE   = 1'b1;
    step();
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.Dout;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(33'd0);
    for (int i = 0; i < 4; i++) begin
      logic [32:0] e;
      rd(32'h7f00 + 32'(i * 4), d);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e[31:0]) begin
        n_fail++;
        $display("FAIL reset_read off=%0d actual=%h required=%h", i * 4, d, e[31:0]);
      end
    end
    n_tests++;
    if (irq !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_irq_state actual=%b/%0d required=0/0", irq, dbg_state);
    end
    wr(32'h7f00, 32'hFFFF_FFFF);
    rd(32'h7f00, d);
    n_tests++;
    if (d !== 32'hF) begin
      n_fail++;
      $display("FAIL ctrl_mask actual=%h required=0000000f", d);
    end
    do_reset();
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic [32:0] e;
    do_reset();
    wr(32'h7f04, 32'd5);
    wr(32'h7f00, 32'h9);                // E0
    bus.Addr = 32'h7f08;
    exp_q.push_back({1'b0, 32'd0});     // E1 LOAD pending
    for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, 32'(5 - k)}); // E2..E6
    exp_q.push_back({1'b1, 32'd0});     // E7
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_tests++;
      if ({irq, bus.Dout} !== e) begin
        n_fail++;
        $display("FAIL oneshot_trace actual irq=%b count=%0d required irq=%b count=%0d",
                 irq, bus.Dout, e[32], e[31:0]);
      end
    end
    step();                             // E8
    rd(32'h7f00, d);
    n_tests++;
    if (d !== 32'h8 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_stop actual ctrl=%h irq=%b required ctrl=00000008 irq=1", d, irq);
    end
    step();
    step();
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_hold actual=%b required=1", irq);
    end
    wr(32'h7f00, 32'h9);
    step();                             // IDLE->LOAD edge
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_rearm actual=%b required=0", irq);
    end
  endtask

  task automatic test_autoreload();
    logic [32:0] e;
    do_reset();
    wr(32'h7f04, 32'd3);
    wr(32'h7f00, 32'hB);                // E0
    bus.Addr = 32'h7f08;
    for (int k = 1; k <= 18; k++)
      exp_q.push_back({(k == 5 || k == 11 || k == 17), 32'd0});
    for (int k = 1; exp_q.size() > 0; k++) begin
      step();
      e = exp_q.pop_front();
      n_tests++;
      if (irq !== e[32]) begin
        n_fail++;
        $display("FAIL autoreload_irq edge=E%0d actual=%b required=%b", k, irq, e[32]);
      end
    end
  endtask

  task automatic test_disable();
    bit found;
    bit saw_irq;
    found   = 1'b0;
    saw_irq = 1'b0;
    do_reset();
    wr(32'h7f04, 32'd100);
    wr(32'h7f00, 32'h9);
    bus.Addr = 32'h7f08;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      if (irq) saw_irq = 1'b1;
      if (bus.Dout == 32'd40) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL disable_reach40 actual=%0d required=40", bus.Dout);
    end
    wr(32'h7f00, 32'h8);
    bus.Addr = 32'h7f08;
    #1;
    exp_q.push_back({1'b0, 32'd40});
    e_check_disable: begin
      logic [32:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if ({irq, bus.Dout} !== e) begin
        n_fail++;
        $display("FAIL disable_write_hold actual irq=%b count=%0d required irq=0 count=40", irq, bus.Dout);
      end
    end
    step();
    n_tests++;
    if (dbg_state !== ST_IDLE || bus.Dout !== 32'd40) begin
      n_fail++;
      $display("FAIL disable_idle actual state=%0d count=%0d required state=0 count=40", dbg_state, bus.Dout);
    end
    for (int k = 0; k < 120; k++) begin
      step();
      if (irq || bus.Dout !== 32'd40) saw_irq = 1'b1;
    end
    n_tests++;
    if (saw_irq) begin
      n_fail++;
      $display("FAIL disable_no_irq actual=irq_or_count_change required=none");
    end
  endtask

  task automatic test_preset_rewrite();
    logic [32:0] e;
    logic [31:0] d;
    do_reset();
    wr(32'h7f04, 32'd4);
    wr(32'h7f00, 32'hB);                // E0
    bus.Addr = 32'h7f08;
    step(); step(); step();             // E1..E3
    n_tests++;
    if (bus.Dout !== 32'd3) begin
      n_fail++;
      $display("FAIL rewrite_pre actual=%0d required=3", bus.Dout);
    end
    wr(32'h7f04, 32'd7);                // E4 write, count holds
    bus.Addr = 32'h7f08;
    exp_q.push_back({1'b0, 32'd2});
    exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b1, 32'd0});
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b0, 32'd0});
    for (int k = 7; k >= 1; k--) exp_q.push_back({1'b0, 32'(k)});
    exp_q.push_back({1'b1, 32'd0});
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_tests++;
      if ({irq, bus.Dout} !== e) begin
        n_fail++;
        $display("FAIL rewrite_trace actual irq=%b count=%0d required irq=%b count=%0d",
                 irq, bus.Dout, e[32], e[31:0]);
      end
    end
    step(); step(); step(); step();     // IDLE, LOAD(7), 7 -> count 6
    n_tests++;
    if (bus.Dout !== 32'd6) begin
      n_fail++;
      $display("FAIL rewrite_reload actual=%0d required=6", bus.Dout);
    end
    wr(32'h7f08, 32'hDEAD_BEEF);
    rd(32'h7f08, d);
    n_tests++;
    if (d !== 32'd6) begin
      n_fail++;
      $display("FAIL count_readonly actual=%0d required=6", d);
    end
    rd(32'h7f04, d);
    n_tests++;
    if (d !== 32'd7) begin
      n_fail++;
      $display("FAIL preset_readback actual=%0d required=7", d);
    end
  endtask

  task automatic test_reset_in_int();
    logic [31:0] d;
    do_reset();
    wr(32'h7f04, 32'd2);
    wr(32'h7f00, 32'h9);
    step(); step(); step(); step();     // E4: INT
    n_tests++;
    if (irq !== 1'b1 || dbg_state !== ST_INT) begin
      n_fail++;
      $display("FAIL int_reached actual irq=%b state=%0d required irq=1 state=3", irq, dbg_state);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if (irq !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL int_reset actual irq=%b state=%0d required irq=0 state=0", irq, dbg_state);
    end
    for (int i = 0; i < 3; i++) begin
      rd(32'h7f00 + 32'(i * 4), d);
      n_tests++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL int_reset_reg off=%0d actual=%h required=0", i * 4, d);
      end
    end
  endtask

  task automatic test_preset_zero_and_mask();
    logic [32:0] e;
    do_reset();
    wr(32'h7f00, 32'h9);                // PRESET=0 acts as 1
    bus.Addr = 32'h7f08;
    exp_q.push_back({1'b0, 32'd0});     // E1
    exp_q.push_back({1'b0, 32'd0});     // E2
    exp_q.push_back({1'b1, 32'd0});     // E3
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_tests++;
      if ({irq, bus.Dout} !== e) begin
        n_fail++;
        $display("FAIL preset0_trace actual irq=%b count=%0d required irq=%b count=%0d",
                 irq, bus.Dout, e[32], e[31:0]);
      end
    end
    step();
    wr(32'h7f00, 32'h0);                // mask
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL im_mask actual=%b required=0", irq);
    end
    step();
    wr(32'h7f00, 32'h8);                // unmask, irq still pending
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL im_unmask actual=%b required=1", irq);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.Addr = 32'h7f00;
    bus.WE   = 1'b0;
    bus.Din  = 32'd0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_disable();
    test_preset_rewrite();
    test_reset_in_int();
    test_preset_zero_and_mask();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
